// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register
// offsets and the vector width.
package irq_pkg;

  localparam int VEC_W = 12;

  localparam logic [2:0] REG_ENABLE  = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_VECBASE = 3'd2;
  localparam logic [2:0] REG_EOI     = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKED   = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt line followed by a
// rising-edge detector that emits a single-cycle pulse.
module irq_sync_edge
  import irq_pkg::*;
(
  input  logic clk,
  input  logic nRst,
  input  logic i_src,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches source edges, picks the lowest-index enabled
// pending source, and runs the IRQ/IRQAck/EOI handshake with the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int               NUM_SRC       = 8,
  parameter logic [VEC_W-1:0] RESET_VECBASE = 12'h800
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [NUM_SRC-1:0] srcIn,
  input  logic               cs,
  input  logic [2:0]         addr,
  input  logic [31:0]        wrData,
  input  logic               wrEn,
  output logic [31:0]        rdData,
  output logic               IRQ,
  output logic [VEC_W-1:0]   IRQn,
  input  logic               IRQAck
);

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_pendEn;
  logic [NUM_SRC-1:0] w_clrMask;
  logic [NUM_SRC-1:0] w_pendingNext;
  logic [3:0]         w_activeIdx;
  logic [VEC_W-1:0]   w_vector;
  logic [31:0]        w_rdMux;
  logic               w_wrStb;
  logic               w_rdStb;
  logic               w_eoiWr;
  logic               w_takeReq;
  logic               w_takeAck;
  logic               w_unused;
  irq_state_t         w_nextState;

  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [VEC_W-1:0]   r_vecBase;
  logic [3:0]         r_activeIdx;
  logic [VEC_W-1:0]   r_irqn;
  logic               r_irq;
  logic [31:0]        r_rdData;
  irq_state_t         r_state;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk    (clk),
      .nRst   (nRst),
      .i_src  (srcIn[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_wrStb  = cs & wrEn;
  assign w_rdStb  = cs & ~wrEn;
  assign w_eoiWr  = w_wrStb && (addr == REG_EOI);
  assign w_pendEn = r_pending & r_enable;
  assign w_vector = r_vecBase + {{(VEC_W-4){1'b0}}, w_activeIdx};
  assign w_unused = &{1'b0, wrData[31:VEC_W]};

  always_comb begin
    w_activeIdx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_pendEn[i]) w_activeIdx = 4'(i);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_takeReq   = 1'b0;
    w_takeAck   = 1'b0;
    case (r_state)
      IDLE: if (|w_pendEn) begin
        w_nextState = REQ;
        w_takeReq   = 1'b1;
      end
      REQ: if (IRQAck) begin
        w_nextState = ACKED;
        w_takeAck   = 1'b1;
      end
      ACKED:   if (!IRQAck) w_nextState = SERVICE;
      SERVICE: if (w_eoiWr) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // New edges are OR-ed in after clearing so that a set always beats a clear.
  always_comb begin
    w_clrMask = '0;
    if (w_wrStb && (addr == REG_PENDING)) w_clrMask = wrData[NUM_SRC-1:0];
    if (w_takeAck) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (r_activeIdx == 4'(i)) w_clrMask[i] = 1'b1;
      end
    end
    w_pendingNext = (r_pending & ~w_clrMask) | w_rise;
  end

  always_comb begin
    w_rdMux = '0;
    case (addr)
      REG_ENABLE:  w_rdMux[NUM_SRC-1:0] = r_enable;
      REG_PENDING: w_rdMux[NUM_SRC-1:0] = r_pending;
      REG_VECBASE: w_rdMux[VEC_W-1:0]   = r_vecBase;
      REG_STATUS: begin
        w_rdMux[9:8] = r_state;
        w_rdMux[3:0] = r_activeIdx;
      end
      default:     w_rdMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_pending   <= '0;
      r_enable    <= '0;
      r_vecBase   <= RESET_VECBASE;
      r_activeIdx <= '0;
      r_irqn      <= '0;
      r_irq       <= 1'b0;
      r_rdData    <= '0;
    end else begin
      r_pending <= w_pendingNext;
      if (w_wrStb && (addr == REG_ENABLE))  r_enable  <= wrData[NUM_SRC-1:0];
      if (w_wrStb && (addr == REG_VECBASE)) r_vecBase <= wrData[VEC_W-1:0];
      if (w_rdStb) r_rdData <= w_rdMux;
      if (w_takeReq) begin
        r_activeIdx <= w_activeIdx;
        r_irqn      <= w_vector;
        r_irq       <= 1'b1;
      end else if (w_takeAck) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign rdData = r_rdData;
  assign IRQ    = r_irq;
  assign IRQn   = r_irqn;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: table-driven register vectors plus
// hand-written handshake sequences, checked through an expected-value queue.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int NSRC = 8;

  logic            clk    = 1'b0;
  logic            nRst   = 1'b0;
  logic [NSRC-1:0] srcIn  = '0;
  logic            cs     = 1'b0;
  logic [2:0]      addr   = '0;
  logic [31:0]     wrData = '0;
  logic            wrEn   = 1'b0;
  logic            IRQAck = 1'b0;
  logic [31:0]     rdData;
  logic            IRQ;
  logic [11:0]     IRQn;

  typedef struct {
    string       name;
    logic [31:0] value;
  } expect_t;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  expect_t expectQ[$];
  vec_t    vecs[$];
  int      passCount  = 0;
  int      checkCount = 0;

  irq_controller #(.NUM_SRC(NSRC), .RESET_VECBASE(12'h800)) dut (
    .clk    (clk),
    .nRst   (nRst),
    .srcIn  (srcIn),
    .cs     (cs),
    .addr   (addr),
    .wrData (wrData),
    .wrEn   (wrEn),
    .rdData (rdData),
    .IRQ    (IRQ),
    .IRQn   (IRQn),
    .IRQAck (IRQAck)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pushExpect(input string n, input logic [31:0] v);
    expectQ.push_back('{n, v});
  endtask

  task automatic checkOutput(input logic [31:0] actual);
    expect_t e;
    checkCount++;
    if (expectQ.size() == 0) begin
      $display("[TB] FAIL scoreboard: got %h with nothing expected", actual);
      return;
    end
    e = expectQ.pop_front();
    if (actual === e.value) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", e.name, actual, e.value);
  endtask

  task automatic checkNow(input string n, input logic [31:0] exp, input logic [31:0] act);
    pushExpect(n, exp);
    checkOutput(act);
  endtask

  task automatic regWrite(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wrEn = 1'b1; addr = a; wrData = d;
    step();
    cs = 1'b0; wrEn = 1'b0;
  endtask

  task automatic regRead(input logic [2:0] a);
    cs = 1'b1; wrEn = 1'b0; addr = a;
    step();
    cs = 1'b0;
  endtask

  task automatic readCheck(input string n, input logic [2:0] a, input logic [31:0] exp);
    pushExpect(n, exp);
    regRead(a);
    checkOutput(rdData);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.wr) regWrite(v.addr, v.data);
    else begin
      pushExpect($sformatf("tableReg%0d", v.addr), v.exp);
      regRead(v.addr);
    end
  endtask

  task automatic pulseSrc(input int idx);
    srcIn[idx] = 1'b1;
    repeat (3) step();
    srcIn[idx] = 1'b0;
  endtask

  task automatic waitIrq(input string n, input logic [11:0] expVec);
    for (int i = 0; i < 20 && !IRQ; i++) step();
    checkNow({n, "Irq"}, 32'd1, {31'd0, IRQ});
    checkNow({n, "Vec"}, {20'd0, expVec}, {20'd0, IRQn});
  endtask

  task automatic serviceEoi();
    IRQAck = 1'b1;
    step();
    IRQAck = 1'b0;
    step();
    regWrite(REG_EOI, 32'h0);
  endtask

  initial begin
    vecs.push_back('{1'b1, REG_ENABLE,  32'h0000_00A5, 32'h0});
    vecs.push_back('{1'b0, REG_ENABLE,  32'h0,         32'h0000_00A5});
    vecs.push_back('{1'b1, REG_ENABLE,  32'h0000_01FF, 32'h0});
    vecs.push_back('{1'b0, REG_ENABLE,  32'h0,         32'h0000_00FF});
    vecs.push_back('{1'b1, REG_VECBASE, 32'hFFFF_F456, 32'h0});
    vecs.push_back('{1'b0, REG_VECBASE, 32'h0,         32'h0000_0456});
    vecs.push_back('{1'b0, 3'd5,        32'h0,         32'h0});
    vecs.push_back('{1'b1, 3'd6,        32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 3'd6,        32'h0,         32'h0});
    vecs.push_back('{1'b0, 3'd7,        32'h0,         32'h0});
    vecs.push_back('{1'b1, REG_EOI,     32'h0,         32'h0});
    vecs.push_back('{1'b0, REG_STATUS,  32'h0,         32'h0});
    vecs.push_back('{1'b1, REG_PENDING, 32'h0000_00FF, 32'h0});
    vecs.push_back('{1'b0, REG_PENDING, 32'h0,         32'h0});
    vecs.push_back('{1'b1, REG_ENABLE,  32'h0,         32'h0});
    vecs.push_back('{1'b1, REG_VECBASE, 32'h0000_0800, 32'h0});
    vecs.push_back('{1'b0, REG_VECBASE, 32'h0,         32'h0000_0800});

    repeat (2) @(posedge clk);
    #2;
    checkNow("resetRdData", 32'h0, rdData);
    checkNow("resetIrq",    32'h0, {31'd0, IRQ});
    checkNow("resetIrqn",   32'h0, {20'd0, IRQn});
    nRst = 1'b1;
    step();
    readCheck("resetEnable",  REG_ENABLE,  32'h0);
    readCheck("resetPending", REG_PENDING, 32'h0);
    readCheck("resetVecbase", REG_VECBASE, 32'h800);
    readCheck("resetStatus",  REG_STATUS,  32'h0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      if (!vecs[k].wr) checkOutput(rdData);
    end

    // rdData must hold through idle cycles and writes
    step();
    checkNow("rdHoldIdle", 32'h800, rdData);
    regWrite(REG_ENABLE, 32'h3);
    checkNow("rdHoldWrite", 32'h800, rdData);
    regWrite(REG_ENABLE, 32'h0);

    // Basic request with exact latency
    regWrite(REG_ENABLE, 32'h04);
    srcIn[2] = 1'b1;
    repeat (3) step();
    checkNow("basicEarlyIrq", 32'd0, {31'd0, IRQ});
    srcIn[2] = 1'b0;
    step();
    checkNow("basicIrq", 32'd1, {31'd0, IRQ});
    checkNow("basicVec", 32'h802, {20'd0, IRQn});
    IRQAck = 1'b1;
    repeat (2) step();
    IRQAck = 1'b0;
    step();
    checkNow("ackIrqLow", 32'd0, {31'd0, IRQ});
    readCheck("ackPending", REG_PENDING, 32'h0);
    readCheck("ackStatus",  REG_STATUS,  32'h302);
    regWrite(REG_EOI, 32'h0);
    readCheck("eoiStatus",  REG_STATUS,  32'h002);

    // Priority: sources 5 and 1 together, lowest index first
    regWrite(REG_ENABLE, 32'hFF);
    srcIn = 8'h22;
    repeat (3) step();
    srcIn = 8'h00;
    waitIrq("prio1", 12'h801);
    regWrite(REG_ENABLE, 32'h0);
    checkNow("reqHoldIrq", 32'd1, {31'd0, IRQ});
    checkNow("reqHoldVec", 32'h801, {20'd0, IRQn});
    regWrite(REG_ENABLE, 32'hFF);
    serviceEoi();
    checkNow("prioGapIrq", 32'd0, {31'd0, IRQ});
    step();
    checkNow("prio2Irq", 32'd1, {31'd0, IRQ});
    checkNow("prio2Vec", 32'h805, {20'd0, IRQn});
    serviceEoi();
    regWrite(REG_ENABLE, 32'h0);

    // Masking and W1C before enabling
    pulseSrc(3);
    repeat (2) step();
    checkNow("maskIrqLow", 32'd0, {31'd0, IRQ});
    readCheck("maskPending", REG_PENDING, 32'h08);
    regWrite(REG_ENABLE, 32'h08);
    checkNow("maskNotYet", 32'd0, {31'd0, IRQ});
    step();
    checkNow("maskIrq", 32'd1, {31'd0, IRQ});
    checkNow("maskVec", 32'h803, {20'd0, IRQn});
    serviceEoi();
    regWrite(REG_ENABLE, 32'h0);
    pulseSrc(3);
    repeat (2) step();
    regWrite(REG_PENDING, 32'h08);
    readCheck("w1cPending", REG_PENDING, 32'h0);
    regWrite(REG_ENABLE, 32'h08);
    repeat (3) step();
    checkNow("w1cNoIrq", 32'd0, {31'd0, IRQ});
    regWrite(REG_ENABLE, 32'h0);

    // Vector wraps modulo 4096
    regWrite(REG_VECBASE, 32'hFFE);
    regWrite(REG_ENABLE, 32'h08);
    pulseSrc(3);
    waitIrq("wrap", 12'h001);
    serviceEoi();
    regWrite(REG_ENABLE, 32'h0);
    regWrite(REG_VECBASE, 32'h800);

    // W1C lands on the same edge as the source-0 rise: set wins
    srcIn[0] = 1'b1;
    repeat (2) step();
    regWrite(REG_PENDING, 32'h01);
    srcIn[0] = 1'b0;
    readCheck("setWins", REG_PENDING, 32'h01);
    regWrite(REG_PENDING, 32'h01);
    readCheck("setWinsClr", REG_PENDING, 32'h0);

    // Asynchronous reset while in REQ
    regWrite(REG_ENABLE, 32'h04);
    pulseSrc(2);
    waitIrq("rstPre", 12'h802);
    #1 nRst = 1'b0;
    #1;
    checkNow("rstIrq",  32'd0, {31'd0, IRQ});
    checkNow("rstIrqn", 32'd0, {20'd0, IRQn});
    step();
    nRst = 1'b1;
    step();
    readCheck("rstEnable",  REG_ENABLE,  32'h0);
    readCheck("rstPending", REG_PENDING, 32'h0);
    readCheck("rstVecbase", REG_VECBASE, 32'h800);
    readCheck("rstStatus",  REG_STATUS,  32'h0);
    repeat (4) step();
    checkNow("rstNoReq", 32'd0, {31'd0, IRQ});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
